microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Parametrised successor to the 8-bit CPU control unit. Holds a writable microcode store indexed by
//  {flags, opcode, step} and runs an internal step counter. The counter supports variable-length
//  instructions (end-of-instruction bit), halt, and run/stop sequencing.
//  Sits between the instruction register/flags register and every control input of the datapath.
// PARAMETERS
//  CW_W     24  control word width (bits driven to datapath)
//  OP_W     4   opcode width (IR upper nibble)
//  FLAG_W   2   flag bits used in microcode address
//  STEP_W   4   step counter width; max 2**STEP_W steps per instruction
//  EOI_BIT  23  control-word bit index meaning "last step of instruction"
//  HLT_BIT  22  control-word bit index meaning "halt after this step"
//  ADDR_W   localparam = FLAG_W+OP_W+STEP_W (store depth 2**ADDR_W)
// PORTS
//  clk        in   1       rising-edge clock
//  RESETn     in   1       asynchronous, active-low reset
//  start      in   1       level; in IDLE/HALT, enter RUN at step 0
//  step_clr   in   1       synchronous step counter clear (next cycle is step 0)
//  flags      in   FLAG_W  flags register output
//  opcode     in   OP_W    instruction register opcode
//  prog_we    in   1       microcode write strobe
//  prog_addr  in   ADDR_W  write address {flags,opcode,step}
//  prog_data  in   CW_W    write data
//  prog_err   out  1       1-cycle pulse: prog_we asserted while RUN (write dropped)
//  ctrl_out   out  CW_W    control word for current step; 0 unless RUN
//  step       out  STEP_W  current step
//  running    out  1       state==RUN
//  halted     out  1       state==HALT
//  instr_done out  1       combinational: RUN and current word has EOI_BIT set
// BEHAVIOUR
//  Reset (async, RESETn=0): state=IDLE, step=0, prog_err=0, so ctrl_out=0, running=0, halted=0.
//   Store contents are NOT cleared.
//  Address = {flag_sel, opcode, step}. Word = store[address], read combinationally (0-cycle latency).
//   ctrl_out = (state==RUN) ? word : 0.
//  FSM: IDLE -start-> RUN; RUN -(word[HLT_BIT])-> HALT; HALT -start-> RUN; no other transitions.
//  Step update in RUN, priority high->low:
//   step_clr -> 0; word[HLT_BIT] -> 0; word[EOI_BIT] -> 0; step==2**STEP_W-1 -> 0 (wrap);
//   otherwise step+1.
//  Step in IDLE/HALT: held at 0; step_clr has no visible effect.
//  HLT and EOI in the same word: HALT wins; step=0; instr_done still 1 that cycle.
//  Writes: accepted in IDLE/HALT at the clock edge. In RUN they are dropped and prog_err=1
//   for the next cycle.
//  start with prog_we in the same IDLE cycle: the write commits and RUN is entered on that same edge.
//   The first RUN cycle reads the updated store.
//  start is ignored while in RUN.
// CONFIGURATION
//  CU_FLAG_LATCH_EN defined: flags are registered into flag_q when step==0 in RUN.
//   flag_sel=flags while step==0, flag_sel=flag_q otherwise, so a flag change mid-instruction
//   does not switch microcode rows. flag_q resets to 0.
//  Not defined: flag_sel=flags (live) every cycle; no flag_q register.
// STRUCTURE
//  Package cu_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
//   Also default widths CW_W/OP_W/FLAG_W/STEP_W and the EOI/HLT bit positions.
//  Sub-module microcode_store #(ADDR_W, CW_W):
//   sync write port (we, waddr, wdata), async read port (raddr, rdata).
//  The top holds the FSM, step counter, address mux, optional flag latch and output gating.
// TESTING
//  1) Reset, then start=1 with an empty store of zeros -> step counts 0..15, wraps to 0; ctrl_out=0.
//  2) Program opcode 1: step0=24'h000410, step1=24'h800021 (EOI) -> steps 0,1,0,1...;
//     instr_done=1 on step 1 only.
//  3) Program word with bit22 at step 2 -> after step 2, halted=1, step=0, ctrl_out=0.
//     Then start=1 -> RUN at step 0.
//  4) prog_we=1 during RUN -> prog_err pulses 1 cycle; a readback after halt shows the old word.
//  5) Assert RESETn=0 mid-instruction (step=3) -> step=0 and ctrl_out=0 immediately, without
//     waiting for clk. The store is intact after reset.
//  6) With CU_FLAG_LATCH_EN: flags 2'b00->2'b01 at step 2 -> rows for flags=00 are used until EOI.
//     Without it, the row switches to flags=01 in the same cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Package: cu_pkg
// Shared constants for the microcode sequencer: FSM state encoding, default
// widths and the control-word bit positions that the sequencer itself decodes
// (end-of-instruction and halt).
package cu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int DEF_CW_W    = 24;
    localparam int DEF_OP_W    = 4;
    localparam int DEF_FLAG_W  = 2;
    localparam int DEF_STEP_W  = 4;
    localparam int DEF_EOI_BIT = 23;
    localparam int DEF_HLT_BIT = 22;

endpackage

// File: rtl/microcode_store.sv
// Module: microcode_store
// Writable microcode RAM: one synchronous write port and one asynchronous
// (zero-latency) read port. Contents are not reset.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write strobe
//   waddr  in   [ADDR_W-1:0] write address
//   wdata  in   [CW_W-1:0]   write data
//   raddr  in   [ADDR_W-1:0] read address
//   rdata  out  [CW_W-1:0]   word at raddr, combinational
module microcode_store #(
    parameter int ADDR_W = 10,
    parameter int CW_W   = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CW_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CW_W-1:0]   rdata
);

    logic [CW_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/microcode_sequencer.sv
// Module: microcode_sequencer
// Microcoded control unit: looks up the control word at {flags, opcode, step}
// in a writable store and steps through it, honouring end-of-instruction and
// halt bits in the word. The store may only be written while not running.
// Optional feature macro: CU_FLAG_LATCH_EN -- freezes the flag part of the
// microcode address for the rest of an instruction once step 0 has passed.
// Ports:
//   clk        in   rising-edge clock
//   RESETn     in   asynchronous active-low reset
//   start      in   IDLE/HALT -> RUN at step 0
//   step_clr   in   force step to 0 on the next edge (RUN only)
//   flags      in   [FLAG_W-1:0] flags register
//   opcode     in   [OP_W-1:0]   instruction opcode
//   prog_we    in   microcode write strobe
//   prog_addr  in   [ADDR_W-1:0] {flags, opcode, step}
//   prog_data  in   [CW_W-1:0]   write data
//   prog_err   out  one-cycle pulse after a write attempted during RUN
//   ctrl_out   out  [CW_W-1:0]   control word, zero unless RUN
//   step       out  [STEP_W-1:0] current step
//   running    out  state is RUN
//   halted     out  state is HALT
//   instr_done out  RUN and current word has the EOI bit
//
// State table
//   IDLE | after reset, store writable, outputs quiet, waits for start
//   RUN  | stepping through microcode, ctrl_out live, writes rejected
//   HALT | stopped by a halt word, store writable, waits for start
module microcode_sequencer
    import cu_pkg::*;
#(
    parameter  int CW_W    = DEF_CW_W,
    parameter  int OP_W    = DEF_OP_W,
    parameter  int FLAG_W  = DEF_FLAG_W,
    parameter  int STEP_W  = DEF_STEP_W,
    parameter  int EOI_BIT = DEF_EOI_BIT,
    parameter  int HLT_BIT = DEF_HLT_BIT,
    localparam int ADDR_W  = FLAG_W + OP_W + STEP_W
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              start,
    input  logic              step_clr,
    input  logic [FLAG_W-1:0] flags,
    input  logic [OP_W-1:0]   opcode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [CW_W-1:0]   prog_data,
    output logic              prog_err,
    output logic [CW_W-1:0]   ctrl_out,
    output logic [STEP_W-1:0] step,
    output logic              running,
    output logic              halted,
    output logic              instr_done
);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              prog_err_q;
    logic [FLAG_W-1:0] flag_sel;
    logic [ADDR_W-1:0] raddr;
    logic [CW_W-1:0]   word;
    logic              run, hlt, eoi;

    assign run = (state_q == ST_RUN);
    assign hlt = word[HLT_BIT];
    assign eoi = word[EOI_BIT];

`ifdef CU_FLAG_LATCH_EN
    // Step 0 picks the flag row from live flags; later steps stay on that row.
    logic [FLAG_W-1:0] flag_q;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            flag_q <= '0;
        end else if (run && (step_q == '0)) begin
            flag_q <= flags;
        end
    end

    assign flag_sel = (step_q == '0) ? flags : flag_q;
`else
    assign flag_sel = flags;
`endif

    assign raddr = {flag_sel, opcode, step_q};

    microcode_store #(
        .ADDR_W (ADDR_W),
        .CW_W   (CW_W)
    ) u_store (
        .clk   (clk),
        .we    (prog_we && !run),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (raddr),
        .rdata (word)
    );

    // Step is only ever non-zero in RUN; halt, EOI and wrap all return it to 0.
    always_comb begin
        state_d = state_q;
        step_d  = '0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hlt) begin
                    state_d = ST_HALT;
                end
                if (step_clr || hlt || eoi || (&step_q)) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            prog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            prog_err_q <= prog_we && run;
        end
    end

    assign prog_err   = prog_err_q;
    assign ctrl_out   = run ? word : '0;
    assign step       = step_q;
    assign running    = run;
    assign halted     = (state_q == ST_HALT);
    assign instr_done = run && eoi;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

    logic        clk;
    logic        RESETn;
    logic        start;
    logic        step_clr;
    logic [1:0]  flags;
    logic [3:0]  opcode;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [23:0] prog_data;
    logic        prog_err;
    logic [23:0] ctrl_out;
    logic [3:0]  step;
    logic        running;
    logic        halted;
    logic        instr_done;

    int n_cmp = 0;
    int n_bad = 0;

    microcode_sequencer dut (
        .clk        (clk),
        .RESETn     (RESETn),
        .start      (start),
        .step_clr   (step_clr),
        .flags      (flags),
        .opcode     (opcode),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_err   (prog_err),
        .ctrl_out   (ctrl_out),
        .step       (step),
        .running    (running),
        .halted     (halted),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [1:0] f, input logic [3:0] op, input logic [3:0] s,
                        input logic [23:0] d);
        prog_we   = 1'b1;
        prog_addr = {f, op, s};
        prog_data = d;
        cyc();
        prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        start    = 1'b0;
        prog_we  = 1'b0;
        step_clr = 1'b0;
        RESETn   = 1'b0;
        cyc();
        RESETn   = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        RESETn = 1'b0; start = 1'b0; step_clr = 1'b0; flags = 2'b00; opcode = 4'd0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        cyc(); cyc();
        n_cmp++; if (step !== 4'd0)     begin n_bad++; $display("FAIL reset_step got %0d want 0", step); end
        n_cmp++; if (ctrl_out !== 24'h0) begin n_bad++; $display("FAIL reset_ctrl got %h want 000000", ctrl_out); end
        n_cmp++; if (running !== 1'b0)  begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
        n_cmp++; if (halted !== 1'b0)   begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
        n_cmp++; if (prog_err !== 1'b0) begin n_bad++; $display("FAIL reset_prog_err got %b want 0", prog_err); end
        RESETn = 1'b1;
        cyc();
        step_clr = 1'b1;
        cyc();
        step_clr = 1'b0;
        n_cmp++; if (step !== 4'd0 || running !== 1'b0) begin
            n_bad++; $display("FAIL idle_step_clr got step=%0d run=%b want 0/0", step, running);
        end
    endtask

    task automatic test_empty_store();
        for (int s = 0; s < 16; s++) prog(2'b00, 4'd0, 4'(s), 24'h0);
        opcode = 4'd0; flags = 2'b00;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            n_cmp++;
            if (step !== 4'(k % 16) || ctrl_out !== 24'h0 || running !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap k=%0d got step=%0d ctrl=%h run=%b want step=%0d ctrl=000000 run=1",
                         k, step, ctrl_out, running, k % 16);
            end
            cyc();
        end
        do_reset();
    endtask

    task automatic test_eoi();
        prog(2'b00, 4'd1, 4'd0, 24'h000410);
        prog(2'b00, 4'd1, 4'd1, 24'h800021);
        opcode = 4'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (step !== 4'(k % 2) || ctrl_out !== ((k % 2 == 1) ? 24'h800021 : 24'h000410)
                || instr_done !== 1'(k % 2)) begin
                n_bad++;
                $display("FAIL eoi k=%0d got step=%0d ctrl=%h done=%b want step=%0d done=%0d",
                         k, step, ctrl_out, instr_done, k % 2, k % 2);
            end
            cyc();
        end
        do_reset();
    endtask

    task automatic test_halt_and_prog_err();
        prog(2'b00, 4'd2, 4'd0, 24'h000001);
        prog(2'b00, 4'd2, 4'd1, 24'h000002);
        prog(2'b00, 4'd2, 4'd2, 24'h400003);
        prog(2'b00, 4'd3, 4'd0, 24'hC00005);
        opcode = 4'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (step !== 4'd0 || ctrl_out !== 24'h000001) begin
            n_bad++; $display("FAIL halt_s0 got step=%0d ctrl=%h want 0/000001", step, ctrl_out); end
        cyc(); cyc();
        n_cmp++; if (step !== 4'd2 || ctrl_out !== 24'h400003 || halted !== 1'b0 || instr_done !== 1'b0) begin
            n_bad++; $display("FAIL halt_s2 got step=%0d ctrl=%h hlt=%b done=%b want 2/400003/0/0",
                              step, ctrl_out, halted, instr_done); end
        cyc();
        n_cmp++; if (halted !== 1'b1 || running !== 1'b0 || step !== 4'd0 || ctrl_out !== 24'h0) begin
            n_bad++; $display("FAIL halt_enter got hlt=%b run=%b step=%0d ctrl=%h want 1/0/0/000000",
                              halted, running, step, ctrl_out); end
        cyc();
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold got %b want 1", halted); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (running !== 1'b1 || halted !== 1'b0 || step !== 4'd0 || ctrl_out !== 24'h000001) begin
            n_bad++; $display("FAIL halt_restart got run=%b hlt=%b step=%0d ctrl=%h want 1/0/0/000001",
                              running, halted, step, ctrl_out); end
        // attempt a write while running
        prog_we = 1'b1; prog_addr = {2'b00, 4'd2, 4'd1}; prog_data = 24'hABCDEF;
        n_cmp++; if (prog_err !== 1'b0) begin n_bad++; $display("FAIL perr_pre got %b want 0", prog_err); end
        cyc();
        prog_we = 1'b0;
        n_cmp++; if (prog_err !== 1'b1 || ctrl_out !== 24'h000002) begin
            n_bad++; $display("FAIL perr_pulse got err=%b ctrl=%h want 1/000002", prog_err, ctrl_out); end
        cyc();
        n_cmp++; if (prog_err !== 1'b0) begin n_bad++; $display("FAIL perr_clear got %b want 0", prog_err); end
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        n_cmp++; if (step !== 4'd1 || ctrl_out !== 24'h000002) begin
            n_bad++; $display("FAIL perr_readback got step=%0d ctrl=%h want 1/000002", step, ctrl_out); end
        cyc(); cyc();
        // halted again; HLT+EOI word selected while halted must not flag instr_done
        opcode = 4'd3;
        #1;
        n_cmp++; if (halted !== 1'b1 || instr_done !== 1'b0) begin
            n_bad++; $display("FAIL halt_done_gate got hlt=%b done=%b want 1/0", halted, instr_done); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (ctrl_out !== 24'hC00005 || instr_done !== 1'b1) begin
            n_bad++; $display("FAIL hlt_eoi_run got ctrl=%h done=%b want C00005/1", ctrl_out, instr_done); end
        cyc();
        n_cmp++; if (halted !== 1'b1 || step !== 4'd0) begin
            n_bad++; $display("FAIL hlt_eoi_halt got hlt=%b step=%0d want 1/0", halted, step); end
        prog(2'b00, 4'd3, 4'd1, 24'h000077);
        n_cmp++; if (prog_err !== 1'b0) begin
            n_bad++; $display("FAIL halt_write_err got %b want 0", prog_err); end
        do_reset();
    endtask

    task automatic test_start_with_write();
        prog(2'b00, 4'd4, 4'd1, 24'h800222);
        opcode = 4'd4;
        prog_we = 1'b1; prog_addr = {2'b00, 4'd4, 4'd0}; prog_data = 24'h111111;
        start = 1'b1;
        cyc();
        prog_we = 1'b0; start = 1'b0;
        n_cmp++; if (running !== 1'b1 || step !== 4'd0 || ctrl_out !== 24'h111111 || prog_err !== 1'b0) begin
            n_bad++; $display("FAIL start_write got run=%b step=%0d ctrl=%h err=%b want 1/0/111111/0",
                              running, step, ctrl_out, prog_err); end
        cyc();
        n_cmp++; if (step !== 4'd1 || ctrl_out !== 24'h800222 || instr_done !== 1'b1) begin
            n_bad++; $display("FAIL start_write_s1 got step=%0d ctrl=%h done=%b want 1/800222/1",
                              step, ctrl_out, instr_done); end
        do_reset();
    endtask

    task automatic test_async_reset_and_clr();
        prog(2'b00, 4'd5, 4'd0, 24'h000050);
        prog(2'b00, 4'd5, 4'd1, 24'h000051);
        prog(2'b00, 4'd5, 4'd2, 24'h000052);
        prog(2'b00, 4'd5, 4'd3, 24'h000053);
        opcode = 4'd5;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        n_cmp++; if (step !== 4'd3 || ctrl_out !== 24'h000053) begin
            n_bad++; $display("FAIL arst_pre got step=%0d ctrl=%h want 3/000053", step, ctrl_out); end
        #2;
        RESETn = 1'b0;
        #1;
        n_cmp++; if (step !== 4'd0 || ctrl_out !== 24'h0 || running !== 1'b0) begin
            n_bad++; $display("FAIL arst_now got step=%0d ctrl=%h run=%b want 0/000000/0",
                              step, ctrl_out, running); end
        cyc();
        RESETn = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (ctrl_out !== 24'h000050) begin
            n_bad++; $display("FAIL arst_store got %h want 000050", ctrl_out); end
        cyc(); cyc();
        step_clr = 1'b1;
        n_cmp++; if (step !== 4'd2 || ctrl_out !== 24'h000052) begin
            n_bad++; $display("FAIL clr_pre got step=%0d ctrl=%h want 2/000052", step, ctrl_out); end
        cyc();
        step_clr = 1'b0;
        n_cmp++; if (step !== 4'd0 || ctrl_out !== 24'h000050 || running !== 1'b1) begin
            n_bad++; $display("FAIL clr_post got step=%0d ctrl=%h run=%b want 0/000050/1",
                              step, ctrl_out, running); end
        do_reset();
    endtask

    task automatic test_flags();
        logic [23:0] exp2, exp3;
`ifdef CU_FLAG_LATCH_EN
        exp2 = 24'h000062; exp3 = 24'h800063;
`else
        exp2 = 24'h000162; exp3 = 24'h800163;
`endif
        for (int s = 0; s < 3; s++) begin
            prog(2'b00, 4'd6, 4'(s), 24'h000060 + 24'(s));
            prog(2'b01, 4'd6, 4'(s), 24'h000160 + 24'(s));
        end
        prog(2'b00, 4'd6, 4'd3, 24'h800063);
        prog(2'b01, 4'd6, 4'd3, 24'h800163);
        flags = 2'b00; opcode = 4'd6;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (ctrl_out !== 24'h000060) begin
            n_bad++; $display("FAIL flag_s0 got %h want 000060", ctrl_out); end
        cyc(); cyc();
        flags = 2'b01;
        #1;
        n_cmp++; if (step !== 4'd2 || ctrl_out !== exp2) begin
            n_bad++; $display("FAIL flag_s2 got step=%0d ctrl=%h want 2/%h", step, ctrl_out, exp2); end
        cyc();
        n_cmp++; if (ctrl_out !== exp3 || instr_done !== 1'b1) begin
            n_bad++; $display("FAIL flag_s3 got ctrl=%h done=%b want %h/1", ctrl_out, instr_done, exp3); end
        cyc();
        n_cmp++; if (step !== 4'd0 || ctrl_out !== 24'h000160) begin
            n_bad++; $display("FAIL flag_next0 got step=%0d ctrl=%h want 0/000160", step, ctrl_out); end
        cyc();
        n_cmp++; if (ctrl_out !== 24'h000161) begin
            n_bad++; $display("FAIL flag_next1 got %h want 000161", ctrl_out); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_empty_store();
        test_eoi();
        test_halt_and_prog_err();
        test_start_with_write();
        test_async_reset_and_clr();
        test_flags();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
